// File: rtl/arb2_mux_rr.sv
// Two-requester round-robin arbiter driving a 2:1 data mux.
// Grants are bursts of up to MAX_BURST beats; the favored side alternates.
module arb2_mux_rr #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       prio_q, prio_d;
  logic       select_q;

  logic       xfer;
  logic       own_req;
  logic       oth_req;
  logic       burst_end;
  logic [1:0] oth_st;

  // Handshake and datapath outputs; valid is forced low during reset.
  always_comb begin
    out_valid = !rst &&
                (((state_q == GRANT0) && req0) ||
                 ((state_q == GRANT1) && req1));
    xfer      = out_valid && out_ready;
    gnt0      = xfer && (state_q == GRANT0);
    gnt1      = xfer && (state_q == GRANT1);
    select    = select_q;
    out_data  = select_q ? d1 : d0;
  end

  // Next-state, burst counter and priority update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_d    = prio_q;
    own_req   = (state_q == GRANT1) ? req1 : req0;
    oth_req   = (state_q == GRANT1) ? req0 : req1;
    oth_st    = (state_q == GRANT1) ? GRANT0 : GRANT1;
    burst_end = !own_req || (xfer && (cnt_q == LAST));
    unique case (1'b1)
      (state_q == IDLE): begin
        cnt_d = 4'd0;
        if (req0 && req1)
          state_d = prio_q ? GRANT1 : GRANT0;
        else if (req0)
          state_d = GRANT0;
        else if (req1)
          state_d = GRANT1;
      end
      (state_q == GRANT0),
      (state_q == GRANT1): begin
        if (burst_end) begin
          cnt_d  = 4'd0;
          prio_d = (state_q == GRANT0);
          if (oth_req)
            state_d = oth_st;
          else if (own_req)
            state_d = state_q;
          else
            state_d = IDLE;
        end else if (xfer) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State registers; select tracks the state it is entering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      prio_q   <= 1'b0;
      select_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prio_q   <= prio_d;
      select_q <= (state_d == GRANT1);
    end
  end

endmodule

// File: tb/tb_arb2_mux_rr.sv
// Bench for arb2_mux_rr: burst-4 and burst-1 instances share stimulus
// and are compared every cycle against an owner/beat-count model.
module tb_arb2_mux_rr;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [7:0] d0, d1;
  logic       out_ready;

  logic       a_g0, a_g1, a_sel, a_vld;
  logic [7:0] a_dat;
  logic       b_g0, b_g1, b_sel, b_vld;
  logic [7:0] b_dat;

  int checks = 0;
  int errors = 0;

  int owner [2];
  int beats [2];
  int fav   [2];
  int mb    [2];

  arb2_mux_rr #(.WIDTH(8), .MAX_BURST(4)) u_a (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .d0(d0), .d1(d1),
    .gnt0(a_g0), .gnt1(a_g1),
    .select(a_sel),
    .out_valid(a_vld),
    .out_ready(out_ready),
    .out_data(a_dat)
  );

  arb2_mux_rr #(.WIDTH(8), .MAX_BURST(1)) u_b (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .d0(d0), .d1(d1),
    .gnt0(b_g0), .gnt1(b_g1),
    .select(b_sel),
    .out_valid(b_vld),
    .out_ready(out_ready),
    .out_data(b_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int k,
                           input logic g0, input logic g1,
                           input logic sel, input logic vld,
                           input logic [7:0] dat);
    logic       mine;
    logic       ev, es;
    logic [7:0] ed;
    mine = (owner[k] == 1) ? req1 : req0;
    ev   = !rst && (owner[k] >= 0) && mine;
    es   = (owner[k] == 1);
    ed   = es ? d1 : d0;
    chk($sformatf("valid%0d", k), 32'(vld), 32'(ev));
    chk($sformatf("select%0d", k), 32'(sel), 32'(es));
    chk($sformatf("data%0d", k), 32'(dat), 32'(ed));
    chk($sformatf("gnt0_%0d", k), 32'(g0),
        32'(ev && out_ready && owner[k] == 0));
    chk($sformatf("gnt1_%0d", k), 32'(g1),
        32'(ev && out_ready && owner[k] == 1));
  endtask

  task automatic model_step(input int k);
    logic mine, theirs, xf;
    if (rst) begin
      owner[k] = -1;
      beats[k] = 0;
      fav[k]   = 0;
    end else if (owner[k] < 0) begin
      if (req0 && req1)
        owner[k] = fav[k];
      else if (req0)
        owner[k] = 0;
      else if (req1)
        owner[k] = 1;
    end else begin
      mine   = (owner[k] == 1) ? req1 : req0;
      theirs = (owner[k] == 1) ? req0 : req1;
      xf     = mine && out_ready;
      if (xf)
        beats[k]++;
      if (!mine || (xf && beats[k] == mb[k])) begin
        fav[k]   = 1 - owner[k];
        owner[k] = theirs ? 1 - owner[k] : (mine ? owner[k] : -1);
        beats[k] = 0;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic a0, input logic a1,
                     input logic [7:0] x0, input logic [7:0] x1,
                     input logic rd);
    @(negedge clk);
    rst = r; req0 = a0; req1 = a1;
    d0 = x0; d1 = x1; out_ready = rd;
    #1;
    check_dut(0, a_g0, a_g1, a_sel, a_vld, a_dat);
    check_dut(1, b_g0, b_g1, b_sel, b_vld, b_dat);
    @(posedge clk);
    model_step(0);
    model_step(1);
  endtask

  initial begin
    logic       r, a0, a1, rd, p0, p1;
    logic [7:0] x0, x1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    d0 = 8'h00; d1 = 8'h00; out_ready = 1'b0;
    mb[0] = 4; mb[1] = 1;
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; beats[k] = 0; fav[k] = 0;
    end
    repeat (2) @(posedge clk);

    // reset state, with requests pending under reset
    cyc(1, 1, 1, 8'h5A, 8'h3C, 1);
    cyc(1, 0, 0, 8'h00, 8'h00, 1);

    // single requester: burst wraps with no bubble
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 0, 8'hA5, 8'h00, 1);
    chk("s1_data", 32'(a_dat), 32'h0000_00A5);
    cyc(0, 0, 0, 8'hA5, 8'h00, 1);
    cyc(0, 0, 0, 8'hA5, 8'h00, 1);

    // contention: 4/4 on u_a, strict alternation on u_b
    for (int i = 0; i < 20; i++)
      cyc(0, 1, 1, 8'h11, 8'h22, 1);

    // backpressure while requester 1 owns u_a
    for (int i = 0; i < 20 && owner[0] != 1; i++)
      cyc(0, 1, 1, 8'h11, 8'h22, 1);
    chk("bp_owner", 32'(owner[0]), 32'd1);
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 1, 8'h11, 8'h22, 0);
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 1, 8'h11, 8'h22, 1);

    // early release of requester 0 after two beats
    cyc(1, 0, 0, 8'h00, 8'h00, 1);
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 1, 8'h33, 8'h44, 1);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 8'h33, 8'h44, 1);

    // reset in the middle of a requester-1 burst
    cyc(1, 0, 0, 8'h00, 8'h00, 1);
    for (int i = 0; i < 7; i++)
      cyc(0, 1, 1, 8'h55, 8'h66, 1);
    cyc(1, 1, 1, 8'h55, 8'h66, 1);
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 1, 8'h55, 8'h66, 1);

    // randomized traffic; data changes only when its request is low
    p0 = 1'b0; p1 = 1'b0;
    x0 = 8'h00; x1 = 8'h00;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      a0 = ($urandom_range(0, 3) != 0);
      a1 = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 3) != 0);
      if (!p0) x0 = 8'($urandom);
      if (!p1) x1 = 8'($urandom);
      cyc(r, a0, a1, x0, x1, rd);
      p0 = a0; p1 = a1;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/arb2_mux_rr.md
ARB2_MUX_RR -- requirements
Module: arb2_mux_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width of each requester and of the output.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, meaning the maximum beats per grant; legal range 1..15.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req0  input  1  requester 0 has a beat to send.
REQ-007 req1  input  1  requester 1 has a beat to send.
REQ-008 d0  input  WIDTH  requester 0 data; must be stable while req0 is high.
REQ-009 d1  input  WIDTH  requester 1 data; must be stable while req1 is high.
REQ-010 gnt0  output  1  one-cycle acknowledge: requester 0 beat consumed this cycle.
REQ-011 gnt1  output  1  one-cycle acknowledge: requester 1 beat consumed this cycle.
REQ-012 select  output  1  2:1 mux select: 0 routes d0, 1 routes d1.
REQ-013 out_valid  output  1  out_data holds a valid beat.
REQ-014 out_ready  input  1  sink accepts the beat this cycle.
REQ-015 out_data  output  WIDTH  selected requester data.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, GRANT0 and GRANT1.
REQ-017 A beat SHALL transfer when out_valid and out_ready are both high (xfer).
REQ-018 select SHALL be a registered output: 1 in GRANT1, 0 in GRANT0 and IDLE.
REQ-019 out_data SHALL be d1 when select=1 and d0 otherwise, combinationally.
REQ-020 out_valid SHALL be (GRANT0 and req0) or (GRANT1 and req1); it SHALL be 0 in IDLE.
REQ-021 gnt0 SHALL equal xfer in GRANT0; gnt1 SHALL equal xfer in GRANT1; both are combinational.
REQ-022 A 4-bit beat counter cnt SHALL increment on each xfer.
REQ-023 A priority bit prio SHALL hold the favored requester.
REQ-024 IDLE, with one request high, SHALL enter that requester's GRANT state on the next edge.
REQ-025 IDLE, with both requests high, SHALL enter GRANT(prio) on the next edge.
REQ-026 IDLE with no request SHALL stay in IDLE; first out_valid follows a request by exactly 1 cycle.
REQ-027 GRANTi SHALL end when req_i is low, or when xfer occurs with cnt == MAX_BURST-1.
REQ-028 At grant end, if the other requester requests, the FSM SHALL enter GRANT(other) with cnt=0.
REQ-029 At grant end, if only req_i requests (burst expired), the FSM SHALL restart GRANTi with cnt=0.
REQ-030 At grant end with no request, the FSM SHALL enter IDLE with cnt=0.
REQ-031 At every grant end from GRANTi, prio SHALL be set to the other requester.
REQ-032 With out_ready low, the FSM SHALL hold state, cnt and out_data, and gnt0/gnt1 SHALL stay 0.
REQ-033 The granted requester dropping req_i mid-burst SHALL end the grant at that edge without a transfer.
REQ-034 The non-granted requester SHALL never receive gnt, and SHALL never appear on out_data while the other holds a grant.
REQ-035 With MAX_BURST=1, each grant SHALL last one beat, giving strict alternation under continuous contention.

Reset
REQ-036 On rst high at a clock edge, the block SHALL set state=IDLE, cnt=0, prio=0 and select=0.
REQ-037 While in reset, out_valid, gnt0 and gnt1 SHALL be 0.
REQ-038 Reset SHALL take priority over all other events, including mid-burst and xfer in the same cycle.
REQ-039 The first arbitration after reset SHALL favor requester 0.

Verification
REQ-040 Scenario single requester: req0=1, d0=8'hA5, out_ready=1 after reset.
- Cycle 1: GRANT0, out_data=A5, gnt0 pulses each cycle.
- cnt wraps after 4 beats and restarts GRANT0 with no bubble.
REQ-041 Scenario contention: req0=req1=1, out_ready=1.
- Grant sequence is 4 beats of 0, then 4 beats of 1, repeating.
- select toggles every 4 cycles; prio alternates.
REQ-042 Scenario backpressure: in GRANT1, out_ready=0 for 3 cycles.
- out_valid=1, out_data=d1, no gnt1 and cnt frozen.
- Transfers resume when out_ready=1.
REQ-043 Scenario early release: req0 drops after 2 beats while req1=1.
- Next cycle is GRANT1 with select=1 and cnt=0.
REQ-044 Scenario reset mid-burst: rst asserted in GRANT1 at cnt=2.
- Next cycle: IDLE, select=0, out_valid=0.
- With both requests high, next grant goes to requester 0.
